// File: rtl/ser_tx.sv
// ser_tx: parallel-to-serial transmitter, MSB-first, valid/ready input, back-to-back framing.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module ser_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pdata,
  input  logic             pvld,
  output logic             prdy,
  output logic             sout,
  output logic             sout_vld,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SER_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
`ifdef SER_PARITY_EN
  logic             par_r, par_n;
`endif

  logic prdy_n, sout_n, sout_vld_n, last_n, busy_n;
  logic accept;

  assign accept = pvld && prdy;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
`ifdef SER_PARITY_EN
    par_n   = par_r;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = pdata;
          cnt_n   = '0;
`ifdef SER_PARITY_EN
          par_n   = ^pdata;
`endif
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
`ifdef SER_PARITY_EN
          state_n = PAR;
          shreg_n = '0;
          cnt_n   = '0;
`else
          if (accept) begin
            shreg_n = pdata;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
          end
`endif
        end else begin
          shreg_n = {shreg[WIDTH-2:0], 1'b0};
          cnt_n   = cnt + 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = pdata;
          cnt_n   = '0;
          par_n   = ^pdata;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        shreg_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next register values and then registered,
  // so each output flop matches a Moore decode of the current state.
  always_comb begin
    prdy_n     = 1'b0;
    sout_n     = 1'b0;
    sout_vld_n = 1'b0;
    last_n     = 1'b0;
    busy_n     = 1'b0;
    case (state_n)
      IDLE: begin
        prdy_n = 1'b1;
      end
      SHIFT: begin
        sout_n     = shreg_n[WIDTH-1];
        sout_vld_n = 1'b1;
        busy_n     = 1'b1;
`ifndef SER_PARITY_EN
        if (cnt_n == CNT_LAST) begin
          last_n = 1'b1;
          prdy_n = 1'b1;
        end
`endif
      end
`ifdef SER_PARITY_EN
      PAR: begin
        sout_n     = par_n;
        sout_vld_n = 1'b1;
        last_n     = 1'b1;
        prdy_n     = 1'b1;
        busy_n     = 1'b1;
      end
`endif
      default: begin
        prdy_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
`ifdef SER_PARITY_EN
      par_r    <= 1'b0;
`endif
      prdy     <= 1'b1;
      sout     <= 1'b0;
      sout_vld <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
`ifdef SER_PARITY_EN
      par_r    <= par_n;
`endif
      prdy     <= prdy_n;
      sout     <= sout_n;
      sout_vld <= sout_vld_n;
      last     <= last_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx: directed checks of ser_tx framing, handshake, backpressure and reset.
module tb_ser_tx;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam logic [4:0] IDLE_O = 5'b10000;

  logic         clk = 1'b0;
  logic         clr;
  logic         pvld;
  logic [W-1:0] pdata;
  logic         prdy, sout, sout_vld, last, busy;
  logic [4:0]   o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ser_tx #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .pdata    (pdata),
    .pvld     (pvld),
    .prdy     (prdy),
    .sout     (sout),
    .sout_vld (sout_vld),
    .last     (last),
    .busy     (busy)
  );

  // {prdy, sout, sout_vld, last, busy}
  assign o = {prdy, sout, sout_vld, last, busy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] frame_out(input logic [W-1:0] d, input int i);
    logic b;
    logic lst;
    if (i < W) b = d[W-1-i];
    else       b = ^d;
    lst = (i == FL - 1);
    return {lst, b, 1'b1, lst, 1'b1};
  endfunction

  task automatic start(input logic [W-1:0] d);
    pdata = d;
    pvld  = 1'b1;
    tick();
  endtask

  task automatic single(input string tag, input logic [W-1:0] d);
    start(d);
    pvld = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check($sformatf("%s[%0d]", tag, i), o, frame_out(d, i));
      tick();
    end
    check({tag, "_idle"}, o, IDLE_O);
  endtask

  initial begin
    clr   = 1'b1;
    pvld  = 1'b0;
    pdata = '0;
    #1;
    check("rst_t0", o, IDLE_O);

    for (int i = 0; i < 4; i++) begin
      pvld  = ~pvld;
      pdata = (i % 2 == 0) ? 8'hFF : 8'hAA;
      tick();
      check($sformatf("rst_hold[%0d]", i), o, IDLE_O);
    end
    pvld = 1'b0;
    clr  = 1'b0;
    tick();
    check("rst_release", o, IDLE_O);

    single("single_d0", 8'hD0);
    tick();
    check("single_idle2", o, IDLE_O);

    start(8'hA5);
    pdata = 8'h3C;
    for (int i = 0; i < 2 * FL; i++) begin
      check($sformatf("b2b[%0d]", i), o, frame_out((i < FL) ? 8'hA5 : 8'h3C, i % FL));
      tick();
      if (i == FL - 1) pvld = 1'b0;
    end
    check("b2b_idle", o, IDLE_O);

    start(8'h00);
    pvld = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i == 3) begin
        pvld  = 1'b1;
        pdata = 8'hFF;
      end
      if (i == 5) pdata = 8'h81;
      check($sformatf("bp_00[%0d]", i), o, frame_out(8'h00, i));
      tick();
      if (i == FL - 1) pvld = 1'b0;
    end
    for (int i = 0; i < FL; i++) begin
      check($sformatf("bp_81[%0d]", i), o, frame_out(8'h81, i));
      tick();
    end
    check("bp_idle", o, IDLE_O);

    start(8'hF0);
    pvld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_f0[%0d]", i), o, frame_out(8'hF0, i));
      tick();
    end
    check("mid_f0[3]", o, frame_out(8'hF0, 3));
    clr = 1'b1;
    #1;
    check("mid_async", o, IDLE_O);
    tick();
    check("mid_held", o, IDLE_O);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("mid_after[%0d]", i), o, IDLE_O);
    end

    single("post_rst_c3", 8'hC3);

`ifdef SER_PARITY_EN
    single("par_07", 8'h07);
    check("par_07_bit", frame_out(8'h07, W), 5'b11111);
    single("par_03", 8'h03);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
